// File: rtl/nn_stage_mem_pkg.sv
// nn_stage_mem_pkg: shared types, constants and helpers for the per-stage memory
package nn_stage_mem_pkg;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   // request container wide enough for every bank; banks use the low bits
   localparam int REQ_AW = 16;
   localparam int REQ_DW = 256;

   typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

   typedef struct packed {
      logic              wr_en;
      logic [REQ_AW-1:0] wr_addr;
      logic [REQ_DW-1:0] wr_data;
      logic              rd_en;
      logic [REQ_AW-1:0] rd_addr;
   } bank_req_t;

   function automatic int max_depth(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int clamp_lat(input int lat);
      return (lat < RD_LAT_MIN) ? RD_LAT_MIN : ((lat > RD_LAT_MAX) ? RD_LAT_MAX : lat);
   endfunction

endpackage

// File: rtl/nn_stage_mem_bank.sv
// nn_stage_mem_bank: one storage bank with write-first bypass, read pipeline and clear port
module nn_stage_mem_bank
   import nn_stage_mem_pkg::*;
#(
   parameter int W      = 32,
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  bank_req_t         req,
   input  logic              clr_en,
   input  logic [REQ_AW-1:0] clr_addr,
   output logic [W-1:0]      rd_data,
   output logic              rd_valid
);

   localparam int AW  = $clog2(DEPTH);
   localparam int LAT = clamp_lat(RD_LAT);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] wr_word;
   logic [W-1:0] rd_word;
   logic         wr_ok;
   logic         rd_ok;
   logic         clr_ok;
   logic         bypass;
   logic         unused_req;
   logic         v1_q;
   logic [W-1:0] d1_q;

   assign wr_word    = req.wr_data[W-1:0];
   assign unused_req = ^req;
   assign wr_ok      = req.wr_addr < REQ_AW'(DEPTH);
   assign rd_ok      = req.rd_addr < REQ_AW'(DEPTH);
   assign clr_ok     = clr_en && (clr_addr < REQ_AW'(DEPTH));
   assign bypass     = req.wr_en && wr_ok && (req.wr_addr == req.rd_addr);
   assign rd_word    = !rd_ok ? '0 : (bypass ? wr_word : mem[req.rd_addr[AW-1:0]]);

   // array write: the clear sequencer overrides the user port
   always_ff @(posedge clk)
      if (clr_ok) mem[clr_addr[AW-1:0]] <= '0;
      else if (req.wr_en && wr_ok) mem[req.wr_addr[AW-1:0]] <= wr_word;

   // first read stage: capture the word on rd_en, hold it otherwise
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= req.rd_en;
         if (req.rd_en) d1_q <= rd_word;
      end

   if (LAT == 1) begin : g_lat1
      assign rd_valid = v1_q;
      assign rd_data  = d1_q;
   end else begin : g_lat2
      logic         v2_q;
      logic [W-1:0] d2_q;
      // second read stage: forward only valid words so rd_data holds between reads
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) d2_q <= d1_q;
         end
      assign rd_valid = v2_q;
      assign rd_data  = d2_q;
   end

endmodule

// File: rtl/nn_stage_mem.sv
// nn_stage_mem: tap/bias/data storage for one layer stage with clear sequencer and ping-pong data
module nn_stage_mem
   import nn_stage_mem_pkg::*;
#(
   parameter int TAP_W          = 192,
   parameter int TAP_DEPTH      = 32,
   parameter int BIAS_W         = 32,
   parameter int BIAS_DEPTH     = 16,
   parameter int DATA_W         = 32,
   parameter int DATA_DEPTH     = 64,
   parameter int RD_LAT         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr_req,
   output logic                          clr_busy,
   input  logic                          data_swap,
   output logic                          data_sel,
   input  logic                          tap_wr_en,
   input  logic [$clog2(TAP_DEPTH)-1:0]  tap_wr_addr,
   input  logic [TAP_W-1:0]              tap_wr_data,
   input  logic                          tap_rd_en,
   input  logic [$clog2(TAP_DEPTH)-1:0]  tap_rd_addr,
   output logic [TAP_W-1:0]              tap_rd_data,
   output logic                          tap_rd_valid,
   input  logic                          bias_wr_en,
   input  logic [$clog2(BIAS_DEPTH)-1:0] bias_wr_addr,
   input  logic [BIAS_W-1:0]             bias_wr_data,
   input  logic                          bias_rd_en,
   input  logic [$clog2(BIAS_DEPTH)-1:0] bias_rd_addr,
   output logic [BIAS_W-1:0]             bias_rd_data,
   output logic                          bias_rd_valid,
   input  logic                          data_wr_en,
   input  logic [$clog2(DATA_DEPTH)-1:0] data_wr_addr,
   input  logic [DATA_W-1:0]             data_wr_data,
   input  logic                          data_rd_en,
   input  logic [$clog2(DATA_DEPTH)-1:0] data_rd_addr,
   output logic [DATA_W-1:0]             data_rd_data,
   output logic                          data_rd_valid
);

   localparam int DAW  = $clog2(DATA_DEPTH);
   localparam int PAW  = $clog2(2 * DATA_DEPTH);
   localparam int MAXD = max_depth(TAP_DEPTH, BIAS_DEPTH, 2 * DATA_DEPTH);
   localparam int CW   = $clog2(MAXD);

   clr_state_t        state;
   clr_state_t        state_d;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_d;
   logic              boot;
   logic [REQ_AW-1:0] clr_addr;
   logic [PAW-1:0]    data_wr_phys;
   logic [PAW-1:0]    data_rd_phys;
   bank_req_t         tap_req;
   bank_req_t         bias_req;
   bank_req_t         data_req;

   // half-linear mapping equals {half, addr} for power-of-two depths;
   // out-of-range logical addresses map to all-ones, beyond the physical depth
   function automatic logic [PAW-1:0] phys(input logic half, input logic [DAW-1:0] a);
      return (32'(a) >= DATA_DEPTH) ? '1 : (half ? PAW'(a) + PAW'(DATA_DEPTH) : PAW'(a));
   endfunction

   assign clr_busy     = state == ST_CLEAR;
   assign clr_addr     = REQ_AW'(cnt);
   assign data_wr_phys = phys(data_sel, data_wr_addr);
   assign data_rd_phys = phys(~data_sel, data_rd_addr);

   assign tap_req = '{wr_en: tap_wr_en & ~clr_busy, wr_addr: REQ_AW'(tap_wr_addr),
                      wr_data: REQ_DW'(tap_wr_data), rd_en: tap_rd_en & ~clr_busy,
                      rd_addr: REQ_AW'(tap_rd_addr)};
   assign bias_req = '{wr_en: bias_wr_en & ~clr_busy, wr_addr: REQ_AW'(bias_wr_addr),
                       wr_data: REQ_DW'(bias_wr_data), rd_en: bias_rd_en & ~clr_busy,
                       rd_addr: REQ_AW'(bias_rd_addr)};
   assign data_req = '{wr_en: data_wr_en & ~clr_busy, wr_addr: REQ_AW'(data_wr_phys),
                       wr_data: REQ_DW'(data_wr_data), rd_en: data_rd_en & ~clr_busy,
                       rd_addr: REQ_AW'(data_rd_phys)};

   // clear sequencer and ping-pong selector registers; swaps are frozen while clearing
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         boot     <= 1'b1;
         data_sel <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         boot     <= 1'b0;
         data_sel <= data_sel ^ (data_swap & ~clr_busy);
      end

   // next state: start on request or right after reset, leave after writing address MAXD-1
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      if (state == ST_IDLE) begin
         if (clr_req || (boot && (CLEAR_ON_RESET != 0))) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      end else begin
         cnt_d = cnt + 1'b1;
         if (cnt == CW'(MAXD - 1)) state_d = ST_IDLE;
      end
   end

   nn_stage_mem_bank #(.W(TAP_W), .DEPTH(TAP_DEPTH), .RD_LAT(RD_LAT)) u_tap (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (tap_req),
      .clr_en   (clr_busy),
      .clr_addr (clr_addr),
      .rd_data  (tap_rd_data),
      .rd_valid (tap_rd_valid)
   );

   nn_stage_mem_bank #(.W(BIAS_W), .DEPTH(BIAS_DEPTH), .RD_LAT(RD_LAT)) u_bias (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (bias_req),
      .clr_en   (clr_busy),
      .clr_addr (clr_addr),
      .rd_data  (bias_rd_data),
      .rd_valid (bias_rd_valid)
   );

   nn_stage_mem_bank #(.W(DATA_W), .DEPTH(2 * DATA_DEPTH), .RD_LAT(RD_LAT)) u_data (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (data_req),
      .clr_en   (clr_busy),
      .clr_addr (clr_addr),
      .rd_data  (data_rd_data),
      .rd_valid (data_rd_valid)
   );

endmodule

// File: tb/tb_nn_stage_mem.sv
// tb_nn_stage_mem: directed vector and sequence checks for nn_stage_mem
module tb_nn_stage_mem;

   localparam logic [191:0] P_A5 = {24{8'hA5}};
   localparam logic [191:0] P_T  = {6{32'h1357_9BDF}};
   localparam logic [191:0] P_FF = {24{8'hFF}};

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr_req, clr_busy, data_swap, data_sel;
   logic         tap_wr_en, tap_rd_en, tap_rd_valid;
   logic [4:0]   tap_wr_addr, tap_rd_addr;
   logic [191:0] tap_wr_data, tap_rd_data;
   logic         bias_wr_en, bias_rd_en, bias_rd_valid;
   logic [3:0]   bias_wr_addr, bias_rd_addr;
   logic [31:0]  bias_wr_data, bias_rd_data;
   logic         data_wr_en, data_rd_en, data_rd_valid;
   logic [5:0]   data_wr_addr, data_rd_addr;
   logic [31:0]  data_wr_data, data_rd_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   nn_stage_mem dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
      .data_swap(data_swap), .data_sel(data_sel),
      .tap_wr_en(tap_wr_en), .tap_wr_addr(tap_wr_addr), .tap_wr_data(tap_wr_data),
      .tap_rd_en(tap_rd_en), .tap_rd_addr(tap_rd_addr), .tap_rd_data(tap_rd_data),
      .tap_rd_valid(tap_rd_valid),
      .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
      .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
      .bias_rd_valid(bias_rd_valid),
      .data_wr_en(data_wr_en), .data_wr_addr(data_wr_addr), .data_wr_data(data_wr_data),
      .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr), .data_rd_data(data_rd_data),
      .data_rd_valid(data_rd_valid)
   );

   typedef struct {
      string        name;
      int           bank;
      logic         wr_en;
      logic [6:0]   wr_addr;
      logic [191:0] wr_data;
      logic         rd_en;
      logic [6:0]   rd_addr;
      logic         valid;
      logic [191:0] data;
   } vec_t;

   vec_t vec [13];

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      clr_req = 0; data_swap = 0;
      tap_wr_en = 0; tap_wr_addr = 0; tap_wr_data = 0; tap_rd_en = 0; tap_rd_addr = 0;
      bias_wr_en = 0; bias_wr_addr = 0; bias_wr_data = 0; bias_rd_en = 0; bias_rd_addr = 0;
      data_wr_en = 0; data_wr_addr = 0; data_wr_data = 0; data_rd_en = 0; data_rd_addr = 0;
   endtask

   task automatic drive(input vec_t v);
      idle();
      case (v.bank)
         0: begin
            tap_wr_en = v.wr_en; tap_wr_addr = v.wr_addr[4:0]; tap_wr_data = v.wr_data;
            tap_rd_en = v.rd_en; tap_rd_addr = v.rd_addr[4:0];
         end
         1: begin
            bias_wr_en = v.wr_en; bias_wr_addr = v.wr_addr[3:0]; bias_wr_data = v.wr_data[31:0];
            bias_rd_en = v.rd_en; bias_rd_addr = v.rd_addr[3:0];
         end
         default: begin
            data_wr_en = v.wr_en; data_wr_addr = v.wr_addr[5:0]; data_wr_data = v.wr_data[31:0];
            data_rd_en = v.rd_en; data_rd_addr = v.rd_addr[5:0];
         end
      endcase
   endtask

   task automatic chk_bank(input string name, input int bank, input logic valid, input logic [191:0] data);
      logic         v;
      logic [191:0] d;
      v = (bank == 0) ? tap_rd_valid : ((bank == 1) ? bias_rd_valid : data_rd_valid);
      d = (bank == 0) ? tap_rd_data : ((bank == 1) ? 192'(bias_rd_data) : 192'(data_rd_data));
      chk({name, "_valid"}, 192'(v), 192'(valid));
      chk({name, "_data"}, d, data);
   endtask

   // counts negedges with clr_busy high, starting at the next negedge; bounded
   task automatic count_busy(output int n);
      n = 0;
      @(negedge clk);
      while (clr_busy && n < 1000) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      vec[0]  = '{"tap31",        0, 1'b0, 7'd0,  192'd0,        1'b1, 7'd31, 1'b1, 192'd0};
      vec[1]  = '{"bias15",       1, 1'b0, 7'd0,  192'd0,        1'b1, 7'd15, 1'b1, 192'd0};
      vec[2]  = '{"data63",       2, 1'b0, 7'd0,  192'd0,        1'b1, 7'd63, 1'b1, 192'd0};
      vec[3]  = '{"tap_wr5",      0, 1'b1, 7'd5,  P_A5,          1'b0, 7'd0,  1'b0, 192'd0};
      vec[4]  = '{"tap_rd5",      0, 1'b0, 7'd0,  192'd0,        1'b1, 7'd5,  1'b1, P_A5};
      vec[5]  = '{"tap_hold",     0, 1'b0, 7'd0,  192'd0,        1'b0, 7'd0,  1'b0, P_A5};
      vec[6]  = '{"bias_bypass",  1, 1'b1, 7'd3,  192'h1234,     1'b1, 7'd3,  1'b1, 192'h1234};
      vec[7]  = '{"bias_rd3",     1, 1'b0, 7'd0,  192'd0,        1'b1, 7'd3,  1'b1, 192'h1234};
      vec[8]  = '{"bias_wr4_rd3", 1, 1'b1, 7'd4,  192'hDEADBEEF, 1'b1, 7'd3,  1'b1, 192'h1234};
      vec[9]  = '{"bias_rd4",     1, 1'b0, 7'd0,  192'd0,        1'b1, 7'd4,  1'b1, 192'hDEADBEEF};
      vec[10] = '{"tap_wr31_rd5", 0, 1'b1, 7'd31, P_T,           1'b1, 7'd5,  1'b1, P_A5};
      vec[11] = '{"tap_rd31",     0, 1'b0, 7'd0,  192'd0,        1'b1, 7'd31, 1'b1, P_T};
      vec[12] = '{"data_wr7_rd7", 2, 1'b1, 7'd7,  192'hCAFE,     1'b1, 7'd7,  1'b1, 192'd0};

      idle();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 192'(clr_busy), 192'd0);
      chk("rst_sel", 192'(data_sel), 192'd0);
      chk_bank("rst_tap", 0, 1'b0, 192'd0);
      chk_bank("rst_bias", 1, 1'b0, 192'd0);
      chk_bank("rst_data", 2, 1'b0, 192'd0);
      rst_n = 1'b1;
      count_busy(n);
      chk("boot_clear_len", 192'(n), 192'd128);

      for (int i = 0; i < 13; i++) begin
         drive(vec[i]);
         @(negedge clk);
         chk_bank(vec[i].name, vec[i].bank, vec[i].valid, vec[i].data);
      end

      // swap cycle still reads the old read half; afterwards data[7] = CAFE is visible
      idle(); data_swap = 1; data_rd_en = 1; data_rd_addr = 7;
      @(negedge clk);
      chk("swap_sel", 192'(data_sel), 192'd1);
      chk_bank("swap_cycle_rd7", 2, 1'b1, 192'd0);
      idle(); data_rd_en = 1; data_rd_addr = 7; data_wr_en = 1; data_wr_addr = 9; data_wr_data = 32'hBEEF;
      @(negedge clk);
      chk_bank("post_swap_rd7", 2, 1'b1, 192'hCAFE);
      idle(); data_rd_en = 1; data_rd_addr = 9;
      @(negedge clk);
      chk_bank("rd9_other_half", 2, 1'b1, 192'd0);

      // clear mid-stream: in-flight read completes, user traffic during clear is dropped
      idle(); clr_req = 1; tap_rd_en = 1; tap_rd_addr = 31;
      @(negedge clk);
      chk("clr_busy_rise", 192'(clr_busy), 192'd1);
      chk_bank("inflight_tap31", 0, 1'b1, P_T);
      n = 0;
      while (clr_busy && n < 1000) begin
         n++;
         idle();
         if (n >= 10 && n < 20) begin
            tap_wr_en = 1; tap_wr_addr = 5; tap_wr_data = P_FF; tap_rd_en = 1; tap_rd_addr = 5;
            bias_wr_en = 1; bias_wr_addr = 2; bias_wr_data = 32'h77; bias_rd_en = 1; bias_rd_addr = 2;
         end
         if (n == 30) clr_req = 1;
         if (n == 31) data_swap = 1;
         @(negedge clk);
         if (n == 10 || n == 19) begin
            chk("clr_tap_rd_dropped", 192'(tap_rd_valid), 192'd0);
            chk("clr_bias_rd_dropped", 192'(bias_rd_valid), 192'd0);
         end
      end
      chk("mid_clear_len", 192'(n), 192'd128);
      chk("swap_ignored_in_clear", 192'(data_sel), 192'd1);
      idle(); tap_rd_en = 1; tap_rd_addr = 5; bias_rd_en = 1; bias_rd_addr = 2; data_rd_en = 1; data_rd_addr = 7;
      @(negedge clk);
      chk_bank("after_clr_tap5", 0, 1'b1, 192'd0);
      chk_bank("after_clr_bias2", 1, 1'b1, 192'd0);
      chk_bank("after_clr_data7", 2, 1'b1, 192'd0);

      // reset at clear cycle 40 aborts the clear; release restarts a full one
      idle(); bias_wr_en = 1; bias_wr_addr = 1; bias_wr_data = 32'hABCD;
      @(negedge clk);
      idle(); bias_rd_en = 1; bias_rd_addr = 1; clr_req = 1;
      @(negedge clk);
      chk_bank("pre_abort_bias1", 1, 1'b1, 192'hABCD);
      idle();
      repeat (39) @(negedge clk);
      chk("pre_abort_busy", 192'(clr_busy), 192'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 192'(clr_busy), 192'd0);
      chk("abort_sel", 192'(data_sel), 192'd0);
      chk_bank("abort_bias", 1, 1'b0, 192'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy(n);
      chk("restart_clear_len", 192'(n), 192'd128);
      chk("restart_sel", 192'(data_sel), 192'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
